// File: rtl/dispense_ctrl.sv
// Vend sequencer: accumulates coin credit, validates keypad slot selections against PRICE,
// runs one slot motor until the drop sensor fires or a timeout expires, and drives the LCD message code.
module dispense_ctrl #(
  parameter int unsigned PRICE        = 4,
  parameter int unsigned N_SLOTS      = 6,
  parameter int unsigned TIMEOUT_CYC  = 150_000_000,
  parameter int unsigned MSG_HOLD_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       fin,
  output logic [2:0] sel_motor,
  output logic [3:0] edo_LCD,
  output logic [3:0] credit,
  output logic       busy
);

  localparam int unsigned DISP_W = (TIMEOUT_CYC  > 1) ? $clog2(TIMEOUT_CYC)  : 1;
  localparam int unsigned HOLD_W = (MSG_HOLD_CYC > 1) ? $clog2(MSG_HOLD_CYC) : 1;
  localparam int unsigned SUM_W  = 6;

  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MSG_HOLD_CYC - 1);
  localparam logic [3:0]        PRICE_U   = 4'(PRICE);
  localparam logic [3:0]        CREDIT_MAX = 4'd15;

  localparam logic [3:0] MSG_WELCOME    = 4'd0;
  localparam logic [3:0] MSG_NEED       = 4'd1;
  localparam logic [3:0] MSG_CHOOSE     = 4'd2;
  localparam logic [3:0] MSG_DISPENSING = 4'd3;
  localparam logic [3:0] MSG_THANKS     = 4'd4;
  localparam logic [3:0] MSG_BAD_KEY    = 4'd5;
  localparam logic [3:0] MSG_JAM        = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPENSE,
    S_DONE,
    S_FAIL,
    S_MSG
  } state_t;

  state_t              state, state_n;
  logic [2:0]          slot, slot_n;
  logic [3:0]          msg_code, msg_code_n;
  logic [DISP_W-1:0]   disp_tmr, disp_tmr_n;
  logic [HOLD_W-1:0]   hold_tmr, hold_tmr_n;
  logic                fin_s1, fin_s2, fin_s3;
  logic                fin_rise;
  logic                key_slot;
  logic                can_buy;
  logic [3:0]          key_msg;
  logic                debit, refund;
  logic [SUM_W-1:0]    credit_sum;
  logic [3:0]          credit_n;
  logic [2:0]          sel_motor_n;
  logic [3:0]          edo_n;
  logic                busy_n;

  // fin is asynchronous: two-flop synchroniser plus a third flop for edge detection
  assign fin_rise = fin_s2 & ~fin_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      slot      <= '0;
      msg_code  <= MSG_WELCOME;
      disp_tmr  <= '0;
      hold_tmr  <= '0;
      fin_s1    <= 1'b0;
      fin_s2    <= 1'b0;
      fin_s3    <= 1'b0;
      sel_motor <= '0;
      edo_LCD   <= MSG_WELCOME;
      credit    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      msg_code  <= msg_code_n;
      disp_tmr  <= disp_tmr_n;
      hold_tmr  <= hold_tmr_n;
      fin_s1    <= fin;
      fin_s2    <= fin_s1;
      fin_s3    <= fin_s2;
      sel_motor <= sel_motor_n;
      edo_LCD   <= edo_n;
      credit    <= credit_n;
      busy      <= busy_n;
    end
  end

  // Next state, timers and credit; outputs are derived from the next state so they register with it
  always_comb begin
    state_n     = state;
    slot_n      = slot;
    msg_code_n  = msg_code;
    disp_tmr_n  = '0;
    hold_tmr_n  = '0;
    debit       = 1'b0;
    refund      = 1'b0;
    key_slot    = (key_code != 4'd0) && (key_code <= 4'(N_SLOTS));
    can_buy     = (credit >= PRICE_U);
    key_msg     = !key_slot ? MSG_BAD_KEY : (can_buy ? MSG_CHOOSE : MSG_NEED);

    unique case (state)
      S_IDLE: begin
        if (key_valid) begin
          if (key_slot && can_buy) begin
            state_n = S_DISPENSE;
            slot_n  = 3'(key_code);
            debit   = 1'b1;
          end else begin
            state_n    = S_MSG;
            msg_code_n = key_msg;
          end
        end
      end
      S_DISPENSE: begin
        if (fin_rise) begin
          state_n = S_DONE;
        end else if (disp_tmr == DISP_LAST) begin
          state_n = S_FAIL;
          refund  = 1'b1;
        end else begin
          disp_tmr_n = disp_tmr + DISP_W'(1);
        end
      end
      S_DONE, S_FAIL: begin
        if (hold_tmr == HOLD_LAST) begin
          state_n = S_IDLE;
        end else begin
          hold_tmr_n = hold_tmr + HOLD_W'(1);
        end
      end
      S_MSG: begin
        if (key_valid) begin
          msg_code_n = key_msg;
        end else if (hold_tmr == HOLD_LAST) begin
          state_n = S_IDLE;
        end else begin
          hold_tmr_n = hold_tmr + HOLD_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Debit only happens with credit >= PRICE, so the sum never underflows
    credit_sum = SUM_W'(credit) + SUM_W'(coin) + (refund ? SUM_W'(PRICE) : SUM_W'(0));
    if (debit) begin
      credit_sum = credit_sum - SUM_W'(PRICE);
    end
    credit_n = (credit_sum > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX : credit_sum[3:0];

    sel_motor_n = (state_n == S_DISPENSE) ? slot_n : 3'd0;
    busy_n      = (state_n == S_DISPENSE) || (state_n == S_DONE) || (state_n == S_FAIL);
    unique case (state_n)
      S_IDLE:     edo_n = (credit_n == 4'd0) ? MSG_WELCOME : MSG_CHOOSE;
      S_DISPENSE: edo_n = MSG_DISPENSING;
      S_DONE:     edo_n = MSG_THANKS;
      S_FAIL:     edo_n = MSG_JAM;
      S_MSG:      edo_n = msg_code_n;
      default:    edo_n = MSG_WELCOME;
    endcase
  end

endmodule
